// File: rtl/reg_rw_ctrl_if.sv
// Request/response channel plus BRAM port bundle for reg_rw_ctrl.
// slave is the controller side; master is the environment (requester, consumer and BRAM).
interface reg_rw_ctrl_if #(
  parameter int unsigned L2_DEPTH = 8,
  parameter int unsigned WIDTH    = 32
) ();
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_opcode;
  logic [L2_DEPTH-1:0] req_index;
  logic [WIDTH-1:0]    req_data;

  logic                resp_valid;
  logic                resp_ready;
  logic [WIDTH-1:0]    resp_data;

  logic                bram_en;
  logic                bram_we;
  logic [L2_DEPTH-1:0] bram_addr;
  logic [WIDTH-1:0]    bram_din;
  logic                bram_regce;
  logic                bram_rst;
  logic [WIDTH-1:0]    bram_dout;

  modport slave (
    input  req_valid, req_opcode, req_index, req_data, resp_ready, bram_dout,
    output req_ready, resp_valid, resp_data,
    output bram_en, bram_we, bram_addr, bram_din, bram_regce, bram_rst
  );

  modport master (
    output req_valid, req_opcode, req_index, req_data, resp_ready, bram_dout,
    input  req_ready, resp_valid, resp_data,
    input  bram_en, bram_we, bram_addr, bram_din, bram_regce, bram_rst
  );
endinterface

// File: rtl/reg_rw_ctrl.sv
// Single-outstanding READ/WRITE/ADD controller for one single-port BRAM with a
// 2-cycle registered read path; ADD is a serialised read-modify-write.
module reg_rw_ctrl #(
  parameter int unsigned L2_DEPTH = 8,
  parameter int unsigned WIDTH    = 32
) (
  input  logic         clk,
  input  logic         rst,
  reg_rw_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StLat1, StLat2, StWrite, StResp} state_e;

  localparam logic [1:0] OpWrite = 2'd1;
  localparam logic [1:0] OpAdd   = 2'd2;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [L2_DEPTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    old_q, old_d;
  logic [WIDTH-1:0]    resp_data_q, resp_data_d;
  logic [WIDTH-1:0]    sum;

  logic                req_ready, resp_valid;
  logic                bram_en, bram_we, bram_regce;
  logic [L2_DEPTH-1:0] bram_addr;
  logic [WIDTH-1:0]    bram_din;

  // Carry out is intentionally discarded (modular add).
  assign sum = old_q + data_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    data_d      = data_q;
    old_d       = old_q;
    resp_data_d = resp_data_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    bram_en     = 1'b0;
    bram_we     = 1'b0;
    bram_regce  = 1'b0;
    bram_addr   = idx_q;
    bram_din    = data_q;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d    = bus.req_opcode;
          idx_d   = bus.req_index;
          data_d  = bus.req_data;
          state_d = StIssue;
        end
      end
      StIssue: begin
        bram_en = 1'b1;
        if (op_q == OpWrite) begin
          bram_we     = 1'b1;
          resp_data_d = data_q;
          state_d     = StResp;
        end else begin
          state_d = StLat1;
        end
      end
      StLat1: begin
        bram_regce = 1'b1;
        state_d    = StLat2;
      end
      StLat2: begin
        old_d = bus.bram_dout;
        if (op_q == OpAdd) begin
          state_d = StWrite;
        end else begin
          // Reserved opcode falls through here and behaves as READ.
          resp_data_d = bus.bram_dout;
          state_d     = StResp;
        end
      end
      StWrite: begin
        bram_en     = 1'b1;
        bram_we     = 1'b1;
        bram_din    = sum;
        resp_data_d = sum;
        state_d     = StResp;
      end
      StResp: begin
        resp_valid = 1'b1;
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      old_q       <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      old_q       <= old_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_data_q;
  assign bus.bram_en    = bram_en;
  assign bus.bram_we    = bram_we;
  assign bus.bram_addr  = bram_addr;
  assign bus.bram_din   = bram_din;
  assign bus.bram_regce = bram_regce;
  assign bus.bram_rst   = rst;

endmodule

// File: doc/reg_rw_ctrl.md
Name: reg_rw_ctrl

Overview:
Single-outstanding request controller that services register-extern operations (READ, WRITE, ADD) from the P4 pipeline against one single-port BRAM. The BRAM has a 2-cycle registered read path. Upstream is a valid/ready request channel; downstream is the BRAM port set plus a valid/ready response channel. ADD is an atomic read-modify-write: no other request is accepted until the write-back completes, so no address hazard exists.

Parameters:
L2_DEPTH, 8, log2 of BRAM entry count; index and address width
WIDTH, 32, data width of a register entry

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_opcode  in  2  0=READ, 1=WRITE, 2=ADD, 3=reserved (executed as READ)
req_index  in  L2_DEPTH  register entry index
req_data  in  WIDTH  write value (WRITE) or addend (ADD); ignored for READ
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_data  out  WIDTH  READ: stored value; WRITE: value written; ADD: new sum
bram_en  out  1  BRAM port enable
bram_we  out  1  BRAM write enable
bram_addr  out  L2_DEPTH  BRAM address
bram_din  out  WIDTH  BRAM write data
bram_regce  out  1  BRAM output register enable
bram_rst  out  1  BRAM output register reset; driven equal to rst
bram_dout  in  WIDTH  BRAM registered read data, valid 2 cycles after a read-enable cycle given regce in between

Behaviour:
- States: IDLE, ISSUE, LAT1, LAT2, WRITE, RESP. Reset → IDLE.
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_data=0, bram_en=0, bram_we=0, bram_regce=0, bram_addr=0, bram_din=0. All registers are cleared.
- IDLE: req_ready=1. A request is accepted when req_valid&&req_ready; opcode, index and data are latched; next state ISSUE. req_ready=0 in every other state.
- ISSUE: bram_en=1, bram_addr=latched index.
  - WRITE: bram_we=1, bram_din=latched data; resp_data←data; next RESP.
  - READ/ADD/reserved: bram_we=0; next LAT1.
- LAT1: bram_regce=1 (sole cycle regce is high); next LAT2.
- LAT2: capture bram_dout as old.
  - READ/reserved: resp_data←old; next RESP.
  - ADD: next WRITE.
- WRITE: bram_en=1, bram_we=1, bram_addr=index, bram_din=(old+data) mod 2^WIDTH (carry discarded, no saturation); resp_data←same sum; next RESP.
- RESP: resp_valid=1. resp_data is held stable until resp_valid&&resp_ready; then next IDLE. A new request is accepted no earlier than the cycle after the handshake.
- Latency, measured from the accept cycle T with resp_ready held high:
  - WRITE: resp_valid at T+2.
  - READ: resp_valid at T+4.
  - ADD: resp_valid at T+5.
  - Throughput: 1 request per (latency+1) cycles.
- bram_en, bram_we and bram_regce are driven combinationally from the state and are low in every state not listed above. bram_addr and bram_din are don't-care when bram_en=0, but the bench checks them only while en=1.
- Back-to-back same index: READ following WRITE/ADD to the same entry returns the updated value, because operations are fully serialised.
- Index wrap: every L2_DEPTH-bit index is valid; no range checking.
- Reset mid-operation: returns to IDLE next cycle; resp_valid drops; any pending WRITE-state write is not issued. An ISSUE-state write already clocked into the BRAM persists. Contents are otherwise unaffected.
- Response backpressure: the FSM stalls in RESP indefinitely, and req_ready stays low throughout.

Test Plan:
- Reset then WRITE idx=0x05 data=0xDEADBEEF → req_ready low T+1, bram_en=bram_we=1 addr=0x05 at T+1, resp_valid at T+2 with resp_data=0xDEADBEEF.
- READ idx=0x05 after the above → bram_en=1 we=0 at T+1, regce=1 at T+2, resp_valid at T+4 with resp_data=0xDEADBEEF; an unwritten idx=0x06 returns 0.
- ADD idx=0x05 data=0x00000002 on 0xFFFFFFFF (WIDTH=32) → write of 0x00000001 at T+4, resp_data=0x00000001 at T+5; subsequent READ returns 0x00000001.
- Back-to-back ADD 1 ×10 to idx=0xFF from 0 with resp_ready=1, req_valid held → final READ 10 (0x0000000A); each accept spaced 6 cycles.
- resp_ready low 5 cycles during READ response → resp_valid and resp_data stable, req_ready=0, no BRAM enables; release → IDLE next cycle.
- rst asserted in LAT2 of an ADD on idx=0x10 holding 7 → next cycle state IDLE, resp_valid=0, no write issued; READ idx=0x10 returns 7.
